// File: rtl/mst_pref_arb.sv
// Round-robin scheduler feeding four generator channels into the shared master pre-fetch FIFO.
// Grants one channel per burst of up to BURST words, gated by FIFO headroom, and tags each word.
module mst_pref_arb #(
   parameter int NCH     = 4,
   parameter int WIDTH   = 36,
   parameter int ADDRBIT = 2,
   parameter int BURST   = 4,
   parameter int THRESH  = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       prefena,
   input  logic [NCH-1:0]             chena,
   input  logic [NCH-1:0]             chrdy,
   output logic [NCH-1:0]             gen_req,
   input  logic [NCH*(WIDTH-4)-1:0]   gen_dat,
   input  logic [ADDRBIT:0]           pref_len,
   output logic                       pref_wr,
   output logic [WIDTH-1:0]           pref_din,
   output logic                       arb_busy,
   output logic [1:0]                 arb_ch
);

   localparam int PW = WIDTH - 4;
   localparam int LW = ADDRBIT + 2;

   typedef enum logic {IDLE, XFER} state_t;

   state_t         state;
   logic [1:0]     rr_ptr;
   logic [1:0]     cur_ch;
   logic [3:0]     beat;
   logic           req_p1;
   logic [1:0]     ch_p1;

   logic [LW-1:0]  fill;
   logic           space;
   logic [NCH-1:0] elig;
   logic [1:0]     pick;
   logic           cur_ok;
   logic           req_vld;
   logic           last_beat;
   logic [PW-1:0]  slice;

   // First eligible channel strictly after ptr, wrapping; the nearest offset is evaluated last and wins.
   function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [NCH-1:0] el);
      logic [1:0] p;
      logic [1:0] idx;
      p = ptr;
      for (int i = NCH; i >= 1; i--) begin
         idx = ptr + 2'(i);
         if (el[idx]) p = idx;
      end
      return p;
   endfunction

   // Headroom counts the write already in flight so the FIFO never overfills.
   assign fill      = LW'(pref_len) + LW'(req_p1);
   assign space     = (fill < LW'(THRESH));
   assign elig      = (prefena && space) ? (chena & chrdy) : '0;
   assign pick      = rr_pick(rr_ptr, elig);
   assign cur_ok    = prefena & chena[cur_ch] & chrdy[cur_ch];
   assign req_vld   = (state == XFER) && cur_ok && space;
   assign last_beat = (beat == 4'(BURST - 1));
   assign gen_req   = req_vld ? (NCH'(1) << cur_ch) : '0;
   assign arb_busy  = (state == XFER);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= 2'(NCH - 1);
         cur_ch <= 2'd0;
         arb_ch <= 2'd0;
         beat   <= 4'd0;
         req_p1 <= 1'b0;
         ch_p1  <= 2'd0;
      end else begin
         // p0 -> p1: request issued now, data returns next cycle
         req_p1 <= req_vld;
         ch_p1  <= cur_ch;
         case (state)
            IDLE: begin
               if (|elig) begin
                  cur_ch <= pick;
                  arb_ch <= pick;
                  beat   <= 4'd0;
                  state  <= XFER;
               end
            end
            XFER: begin
               if (req_vld) beat <= beat + 4'd1;
               // Space starvation only stalls; loss of enable/ready or a full burst ends the grant.
               if (!cur_ok || (req_vld && last_beat)) begin
                  state  <= IDLE;
                  rr_ptr <= cur_ch;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // p1: write the returned word with its channel tag
   always_comb begin
      slice = gen_dat[int'(ch_p1)*PW +: PW];
   end

   assign pref_wr  = req_p1;
   assign pref_din = {2'b11, ch_p1, slice};

endmodule

// File: tb/tb_mst_pref_arb.sv
// Directed, table-driven bench for mst_pref_arb: per-cycle input/expected-output rows plus
// a hand-written asynchronous-reset-mid-burst sequence.
module tb_mst_pref_arb;

   localparam int NCH = 4;
   localparam int WIDTH = 36;
   localparam int PW = WIDTH - 4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 prefena;
   logic [NCH-1:0]       chena;
   logic [NCH-1:0]       chrdy;
   logic [NCH-1:0]       gen_req;
   logic [NCH*PW-1:0]    gen_dat;
   logic [2:0]           pref_len;
   logic                 pref_wr;
   logic [WIDTH-1:0]     pref_din;
   logic                 arb_busy;
   logic [1:0]           arb_ch;

   int checks = 0;
   int errors = 0;

   mst_pref_arb dut (
      .clk(clk), .rst_n(rst_n), .prefena(prefena), .chena(chena), .chrdy(chrdy),
      .gen_req(gen_req), .gen_dat(gen_dat), .pref_len(pref_len), .pref_wr(pref_wr),
      .pref_din(pref_din), .arb_busy(arb_busy), .arb_ch(arb_ch)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       pe;
      logic [3:0] ena;
      logic [3:0] rdy;
      logic [2:0] len;
      logic [3:0] req;
      logic       wr;
      logic [1:0] wch;
      logic       busy;
      logic [1:0] ach;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [PW-1:0] pay(input int k, input int i);
      return 32'hD000_0000 + 32'(k * 4096) + 32'(i);
   endfunction

   task automatic set_dat(input int i);
      for (int k = 0; k < NCH; k++) gen_dat[k*PW +: PW] = pay(k, i);
   endtask

   task automatic add(input logic pe, input logic [3:0] ena, input logic [3:0] rdy,
                      input logic [2:0] len, input logic [3:0] req, input logic wr,
                      input logic [1:0] wch, input logic busy, input logic [1:0] ach);
      vec_t v;
      v.pe = pe; v.ena = ena; v.rdy = rdy; v.len = len; v.req = req;
      v.wr = wr; v.wch = wch; v.busy = busy; v.ach = ach;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      // Scenario B: all channels eligible from reset, grants ch0..ch3 then ch0
      add(1, 4'hF, 4'hF, 0, 4'h0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         add(1, 4'hF, 4'hF, 0, 4'(1 << k), 0, 0, 1, 2'(k));
         for (int j = 0; j < 3; j++) add(1, 4'hF, 4'hF, 0, 4'(1 << k), 1, 2'(k), 1, 2'(k));
         add(1, 4'hF, 4'hF, 0, 4'h0, 1, 2'(k), 0, 2'(k));
      end
      add(1, 4'hF, 4'hF, 0, 4'h1, 0, 0, 1, 0);
      add(1, 4'hF, 4'h0, 0, 4'h0, 1, 0, 1, 0);   // chrdy drop aborts ch0
      add(1, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 0);
      // Scenario A: ch2 alone, full burst of 4
      add(1, 4'hF, 4'h4, 0, 4'h0, 0, 0, 0, 0);
      add(1, 4'hF, 4'h4, 0, 4'h4, 0, 0, 1, 2);
      for (int j = 0; j < 3; j++) add(1, 4'hF, 4'h4, 0, 4'h4, 1, 2, 1, 2);
      add(1, 4'hF, 4'h0, 0, 4'h0, 1, 2, 0, 2);
      add(1, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 2);
      // Scenario C: ch3 under FIFO backpressure, beat count preserved
      add(1, 4'hF, 4'h8, 0, 4'h0, 0, 0, 0, 2);
      add(1, 4'hF, 4'h8, 0, 4'h8, 0, 0, 1, 3);
      add(1, 4'hF, 4'h8, 3, 4'h0, 1, 3, 1, 3);
      add(1, 4'hF, 4'h8, 3, 4'h0, 0, 0, 1, 3);
      add(1, 4'hF, 4'h8, 2, 4'h8, 0, 0, 1, 3);
      add(1, 4'hF, 4'h8, 2, 4'h0, 1, 3, 1, 3);   // 2 + in-flight write hits THRESH
      add(1, 4'hF, 4'h8, 1, 4'h8, 0, 0, 1, 3);
      add(1, 4'hF, 4'h8, 1, 4'h8, 1, 3, 1, 3);   // 4th request ends burst
      add(1, 4'hF, 4'h0, 0, 4'h0, 1, 3, 0, 3);
      add(1, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 3);
      // Scenario D: chena[1] dropped after 2nd request, next grant ch2
      add(1, 4'hF, 4'h6, 0, 4'h0, 0, 0, 0, 3);
      add(1, 4'hF, 4'h6, 0, 4'h2, 0, 0, 1, 1);
      add(1, 4'hF, 4'h6, 0, 4'h2, 1, 1, 1, 1);
      add(1, 4'hD, 4'h6, 0, 4'h0, 1, 1, 1, 1);
      add(1, 4'hD, 4'h6, 0, 4'h0, 0, 0, 0, 1);
      add(1, 4'hD, 4'h6, 0, 4'h4, 0, 0, 1, 2);
      // Scenario E: prefena low for 5 cycles with everything ready
      add(0, 4'hF, 4'hF, 0, 4'h0, 1, 2, 1, 2);
      for (int j = 0; j < 4; j++) add(0, 4'hF, 4'hF, 0, 4'h0, 0, 0, 0, 2);

      rst_n = 1'b0; prefena = 1'b0; chena = '0; chrdy = '0; pref_len = '0;
      set_dat(0);
      repeat (2) @(negedge clk);
      #2;
      chk("reset gen_req", 64'(gen_req), 64'h0);
      chk("reset pref_wr", 64'(pref_wr), 64'h0);
      chk("reset arb_busy", 64'(arb_busy), 64'h0);
      chk("reset arb_ch", 64'(arb_ch), 64'h0);
      chk("reset pref_din", 64'(pref_din), 64'({4'hC, pay(0, 0)}));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         prefena = vecs[i].pe; chena = vecs[i].ena; chrdy = vecs[i].rdy;
         pref_len = vecs[i].len;
         set_dat(i + 1);
         #2;
         chk($sformatf("row%0d gen_req", i), 64'(gen_req), 64'(vecs[i].req));
         chk($sformatf("row%0d pref_wr", i), 64'(pref_wr), 64'(vecs[i].wr));
         chk($sformatf("row%0d arb_busy", i), 64'(arb_busy), 64'(vecs[i].busy));
         chk($sformatf("row%0d arb_ch", i), 64'(arb_ch), 64'(vecs[i].ach));
         if (vecs[i].wr)
            chk($sformatf("row%0d pref_din", i), 64'(pref_din),
                64'({2'b11, vecs[i].wch, pay(int'(vecs[i].wch), i + 1)}));
      end

      // Asynchronous reset in the middle of a ch3 burst
      @(negedge clk);
      prefena = 1'b1; chena = 4'hF; chrdy = 4'h8; pref_len = 0; set_dat(200);
      #2;
      chk("rst_seq idle gen_req", 64'(gen_req), 64'h0);
      @(negedge clk);
      set_dat(201);
      #2;
      chk("rst_seq first req", 64'(gen_req), 64'h8);
      chk("rst_seq arb_ch", 64'(arb_ch), 64'h3);
      @(negedge clk);
      set_dat(202);
      #2;
      chk("rst_seq second req", 64'(gen_req), 64'h8);
      chk("rst_seq write tag F", 64'(pref_din), 64'({4'hF, pay(3, 202)}));
      #1 rst_n = 1'b0;
      #1;
      chk("async rst gen_req", 64'(gen_req), 64'h0);
      chk("async rst pref_wr", 64'(pref_wr), 64'h0);
      chk("async rst arb_busy", 64'(arb_busy), 64'h0);
      chk("async rst arb_ch", 64'(arb_ch), 64'h0);
      chk("async rst pref_din", 64'(pref_din), 64'({4'hC, pay(0, 202)}));
      @(negedge clk);
      rst_n = 1'b1; chrdy = 4'hF; set_dat(203);
      #2;
      chk("post rst pref_wr", 64'(pref_wr), 64'h0);
      chk("post rst gen_req", 64'(gen_req), 64'h0);
      @(negedge clk);
      set_dat(204);
      #2;
      chk("post rst grant ch0", 64'(gen_req), 64'h1);
      chk("post rst arb_ch", 64'(arb_ch), 64'h0);
      chk("post rst no write yet", 64'(pref_wr), 64'h0);
      @(negedge clk);
      set_dat(205);
      #2;
      chk("post rst first write", 64'(pref_wr), 64'h1);
      chk("post rst write tag C", 64'(pref_din), 64'({4'hC, pay(0, 205)}));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
